// File: rtl/cdr_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cdr_phase_ctrl
//  Purpose  : Phase tracker for a 2x-oversampled serial stream. Each accepted
//             4-sample word holds two bit periods. Edges are counted at the
//             two candidate sampling positions over a window of words. The
//             sampling phase moves to the quieter position when the edge
//             margin exceeds THRESH. Lock is declared after LOCK_WIN
//             consecutive switch-free windows that contained edges.
//
//  Parameters
//    WINDOW   : accepted words per phase-decision window (>= 2)
//    THRESH   : edge-count margin required to switch sampling phase
//    LOCK_WIN : consecutive good windows required to declare lock
//
//  Ports
//    clk       in   rising-edge clock
//    rst_n     in   asynchronous active-low reset
//    en        in   tracker enable; low returns the tracker to IDLE
//    in_valid  in   in_data carries a new word this cycle
//    in_data   in   [3:0] samples s0..s3, bit 0 earliest
//    out_valid out  out_data/out_num valid this cycle
//    out_data  out  [1:0] recovered bits, bit 0 earliest, unused bits 0
//    out_num   out  [1:0] number of valid bits in out_data (1 or 2)
//    phase     out  sampling phase (0: s0,s2  1: s1,s3)
//    locked    out  tracker is in LOCK
//    slip      out  one-cycle pulse whenever phase changes
//
//  Revision : 1.0  initial release
// ============================================================================
module cdr_phase_ctrl #(
  parameter int WINDOW   = 16,
  parameter int THRESH   = 4,
  parameter int LOCK_WIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       out_valid,
  output logic [1:0] out_data,
  output logic [1:0] out_num,
  output logic       phase,
  output logic       locked,
  output logic       slip
);

  // Sums reach at most 2*WINDOW; counter spans 0..WINDOW-1; good count
  // spans 0..LOCK_WIN.
  localparam int SUM_W  = $clog2(2 * WINDOW + 1);
  localparam int CNT_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int GOOD_W = (LOCK_WIN > 1) ? $clog2(LOCK_WIN + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_wcnt;
  logic [SUM_W-1:0]   r_sum_a;
  logic [SUM_W-1:0]   r_sum_b;
  logic               r_prev;     // s3 of the previous accepted word
  logic [GOOD_W-1:0]  r_good;
  logic               r_phase;
  logic               r_drop;     // next word's s0 repeats the last s3
  logic               r_out_valid;
  logic [1:0]         r_out_data;
  logic [1:0]         r_out_num;
  logic               r_slip;

  logic               w_accept;
  logic [1:0]         w_ea;
  logic [1:0]         w_eb;
  logic [SUM_W-1:0]   w_tot_a;
  logic [SUM_W-1:0]   w_tot_b;
  logic [31:0]        w_tot_a32;
  logic [31:0]        w_tot_b32;
  logic               w_win_end;
  logic               w_to1;
  logic               w_to0;
  logic               w_switch;
  logic               w_quiet;
  logic [GOOD_W-1:0]  w_good_inc;
  logic               w_good_full;

  // --------------------------------------------------------------------------
  // Edge detection on the stream p, s0, s1, s2, s3
  //   position A: p|s0 and s1|s2 boundaries (edges seen when sampling s0,s2)
  //   position B: s0|s1 and s2|s3 boundaries (edges seen when sampling s1,s3)
  // --------------------------------------------------------------------------
  assign w_accept  = en && in_valid && (r_state != ST_IDLE);

  assign w_ea      = {1'b0, r_prev ^ in_data[0]}     + {1'b0, in_data[1] ^ in_data[2]};
  assign w_eb      = {1'b0, in_data[0] ^ in_data[1]} + {1'b0, in_data[2] ^ in_data[3]};

  assign w_tot_a   = r_sum_a + {{(SUM_W-2){1'b0}}, w_ea};
  assign w_tot_b   = r_sum_b + {{(SUM_W-2){1'b0}}, w_eb};
  assign w_tot_a32 = 32'(w_tot_a);
  assign w_tot_b32 = 32'(w_tot_b);

  assign w_win_end = w_accept && (r_wcnt == CNT_W'(WINDOW - 1));

  // Strict comparison: a margin of exactly THRESH never switches.
  assign w_to1     = !r_phase && (w_tot_b32 > w_tot_a32 + 32'(THRESH));
  assign w_to0     =  r_phase && (w_tot_a32 > w_tot_b32 + 32'(THRESH));
  assign w_switch  = w_win_end && (w_to1 || w_to0);
  assign w_quiet   = (w_tot_a == '0) && (w_tot_b == '0);

  assign w_good_inc  = r_good + 1'b1;
  assign w_good_full = (32'(w_good_inc) >= 32'(LOCK_WIN));

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (w_win_end && !w_switch && !w_quiet && w_good_full) begin
            w_state_nxt = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_switch) begin
            w_state_nxt = ST_ACQ;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Window accumulation, phase decision and good-window counting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_sum_a <= '0;
      r_sum_b <= '0;
      r_prev  <= 1'b0;
      r_good  <= '0;
      r_phase <= 1'b0;
      r_drop  <= 1'b0;
      r_slip  <= 1'b0;
    end else begin
      r_slip <= w_switch;
      if (r_state == ST_IDLE) begin
        // Phase is deliberately kept across IDLE.
        r_wcnt  <= '0;
        r_sum_a <= '0;
        r_sum_b <= '0;
        r_prev  <= 1'b0;
        r_good  <= '0;
        r_drop  <= 1'b0;
      end else if (w_accept) begin
        r_prev <= in_data[3];
        // Leaving phase 1 for phase 0 makes the next s0 a second look at
        // the bit already delivered as s3, so that bit is dropped once.
        r_drop <= w_switch && r_phase;
        if (w_win_end) begin
          r_wcnt  <= '0;
          r_sum_a <= '0;
          r_sum_b <= '0;
          r_phase <= r_phase ^ w_switch;
          if (w_switch || (r_state == ST_ACQ && w_quiet)) begin
            r_good <= '0;
          end else if (r_state == ST_ACQ) begin
            r_good <= w_good_inc;
          end
        end else begin
          r_wcnt  <= r_wcnt + 1'b1;
          r_sum_a <= w_tot_a;
          r_sum_b <= w_tot_b;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Recovered data, one cycle after each accepted word
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 2'b00;
      r_out_num   <= 2'd0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        if (r_phase) begin
          r_out_data <= {in_data[3], in_data[1]};
          r_out_num  <= 2'd2;
        end else if (r_drop) begin
          r_out_data <= {1'b0, in_data[2]};
          r_out_num  <= 2'd1;
        end else begin
          r_out_data <= {in_data[2], in_data[0]};
          r_out_num  <= 2'd2;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_num   = r_out_num;
  assign phase     = r_phase;
  assign locked    = (r_state == ST_LOCK);
  assign slip      = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_cdr_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdr_phase_ctrl
//  Purpose  : Self-checking bench for cdr_phase_ctrl. A word-level model keeps
//             each window's 5-sample streams and counts transitions at the
//             two sampling positions when the window fills; its predictions
//             are compared with the DUT every cycle. Directed scenarios add
//             literal expectations at key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdr_phase_ctrl;

  localparam int WINDOW   = 16;
  localparam int THRESH   = 4;
  localparam int LOCK_WIN = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic [1:0] out_data;
  logic [1:0] out_num;
  logic       phase;
  logic       locked;
  logic       slip;

  int checks = 0;
  int errors = 0;

  cdr_phase_ctrl #(
    .WINDOW  (WINDOW),
    .THRESH  (THRESH),
    .LOCK_WIN(LOCK_WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_num  (out_num),
    .phase    (phase),
    .locked   (locked),
    .slip     (slip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  //   m_mode: 0 idle, 1 acquiring, 2 locked
  //   m_win : 5-sample streams {s3,s2,s1,s0,p} of the current window
  // --------------------------------------------------------------------------
  int         m_mode;
  bit         m_phase;
  bit         m_prev;
  bit         m_drop;
  int         m_good;
  bit [4:0]   m_win[$];
  int         sa, sb;
  bit         sw;
  logic       exp_valid, exp_slip, exp_phase, exp_locked;
  logic [1:0] exp_data, exp_num;

  task automatic model_clear();
    m_prev = 1'b0;
    m_good = 0;
    m_drop = 1'b0;
    m_win.delete();
  endtask

  always @(negedge rst_n) begin
    model_clear();
    m_mode     = 0;
    m_phase    = 1'b0;
    exp_valid  = 1'b0;
    exp_slip   = 1'b0;
    exp_data   = 2'b00;
    exp_num    = 2'd0;
    exp_phase  = 1'b0;
    exp_locked = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      exp_valid = 1'b0;
      exp_slip  = 1'b0;
      if (!en) begin
        m_mode = 0;
        model_clear();
      end else if (m_mode == 0) begin
        m_mode = 1;
        model_clear();
      end else if (in_valid) begin
        exp_valid = 1'b1;
        if (m_phase) begin
          exp_data = {in_data[3], in_data[1]};
          exp_num  = 2'd2;
        end else if (m_drop) begin
          exp_data = {1'b0, in_data[2]};
          exp_num  = 2'd1;
        end else begin
          exp_data = {in_data[2], in_data[0]};
          exp_num  = 2'd2;
        end
        m_drop = 1'b0;
        m_win.push_back({in_data, m_prev});
        m_prev = in_data[3];
        if (m_win.size() == WINDOW) begin
          sa = 0;
          sb = 0;
          foreach (m_win[i]) begin
            for (int k = 0; k < 4; k++) begin
              if (m_win[i][k] != m_win[i][k+1]) begin
                if (k % 2 == 0) sa++;
                else            sb++;
              end
            end
          end
          sw = (!m_phase && sb > sa + THRESH) || (m_phase && sa > sb + THRESH);
          if (sw) begin
            if (m_phase) m_drop = 1'b1;
            m_phase  = !m_phase;
            exp_slip = 1'b1;
            m_good   = 0;
            m_mode   = 1;
          end else if (m_mode == 1) begin
            if (sa + sb == 0) begin
              m_good = 0;
            end else begin
              m_good++;
              if (m_good >= LOCK_WIN) m_mode = 2;
            end
          end
          m_win.delete();
        end
      end
      exp_phase  = m_phase;
      exp_locked = (m_mode == 2);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("slip",      32'(slip),      32'(exp_slip));
      chk("phase",     32'(phase),     32'(exp_phase));
      chk("locked",    32'(locked),    32'(exp_locked));
      if (exp_valid === 1'b1) begin
        chk("out_data", 32'(out_data), 32'(exp_data));
        chk("out_num",  32'(out_num),  32'(exp_num));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input bit v, input bit [3:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  // Reset, then release with en high; the following edge leaves IDLE.
  task automatic restart();
    @(negedge clk);
    en       = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic wait_slip(input int max, input bit [3:0] d);
    int n;
    n = 0;
    while (slip !== 1'b1 && n < max) begin
      drive(1'b1, d);
      n++;
    end
    if (slip !== 1'b1) chk("slip_timeout", 32'(slip), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_num",   32'(out_num),   32'd0);
    chk("rst_phase",     32'(phase),     32'd0);
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_slip",      32'(slip),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Steady 1100: edges only at position A, phase 0 holds, lock after 64.
    @(negedge clk);
    en = 1'b1;
    repeat (72) drive(1'b1, 4'b1100);
    chk("lock_1100",      32'(locked),   32'd1);
    chk("phase_1100",     32'(phase),    32'd0);
    chk("data_1100",      32'(out_data), 32'h2);
    chk("num_1100",       32'(out_num),  32'd2);

    // Stream 0110: edges at position B, switch to phase 1.
    wait_slip(40, 4'b0110);
    chk("phase_after_0110", 32'(phase),  32'd1);
    chk("unlock_0110",      32'(locked), 32'd0);
    drive(1'b1, 4'b0110);
    chk("data_0110", 32'(out_data), 32'h1);
    chk("num_0110",  32'(out_num),  32'd2);
    repeat (80) drive(1'b1, 4'b0110);
    chk("lock_phase1", 32'(locked), 32'd1);

    // Back to 1100 from locked phase 1: switch to 0, drop one bit.
    wait_slip(40, 4'b1100);
    chk("phase_back0", 32'(phase),  32'd0);
    chk("unlock_back", 32'(locked), 32'd0);
    drive(1'b1, 4'b1100);
    chk("drop_valid", 32'(out_valid), 32'd1);
    chk("drop_num",   32'(out_num),   32'd1);
    chk("drop_data",  32'(out_data),  32'h1);
    drive(1'b1, 4'b1100);
    chk("after_drop_num", 32'(out_num), 32'd2);

    // Margin equal to THRESH keeps phase; one more edge pair switches.
    restart();
    repeat (2)  drive(1'b1, 4'b0110);
    repeat (14) drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    chk("eq_no_slip",  32'(slip),  32'd0);
    chk("eq_phase",    32'(phase), 32'd0);
    repeat (3)  drive(1'b1, 4'b0110);
    repeat (12) drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    chk("gt_slip",  32'(slip),  32'd1);
    chk("gt_phase", 32'(phase), 32'd1);

    // in_valid every other cycle: window needs 16 accepted words.
    restart();
    for (int i = 0; i < 30; i++) drive(i % 2 == 0, 4'b0110);
    chk("gap_phase_15w", 32'(phase), 32'd0);
    for (int i = 30; i < 40; i++) drive(i % 2 == 0, 4'b0110);
    chk("gap_phase_20w", 32'(phase), 32'd1);

    // Asynchronous reset mid-window discards partial sums.
    restart();
    repeat (10) drive(1'b1, 4'b0110);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_data",   32'(out_data),  32'd0);
    chk("mid_rst_num",    32'(out_num),   32'd0);
    chk("mid_rst_locked", 32'(locked),    32'd0);
    chk("mid_rst_slip",   32'(slip),      32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) drive(1'b1, 4'b0110);
    chk("post_rst_15w", 32'(phase), 32'd0);
    drive(1'b1, 4'b0110);
    chk("post_rst_slip",  32'(slip),  32'd1);
    chk("post_rst_phase", 32'(phase), 32'd1);

    // en low forces IDLE and ignores in_valid; phase is kept.
    @(negedge clk);
    en = 1'b0;
    repeat (5) drive(1'b1, 4'b1100);
    chk("dis_valid",  32'(out_valid), 32'd0);
    chk("dis_locked", 32'(locked),    32'd0);
    chk("dis_phase",  32'(phase),     32'd1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
